mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register and consumes the registered write-back triple plus the memory-operation fields. It runs loads and stores on a single-outstanding req/ack data bus and stalls the upstream pipeline while a transfer is in flight. It delivers the final write-back triple (ALU result or aligned load data) to MEM/WB.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/load_align.sv | 26 ++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - memory op codes, MEM-stage FSM states and op decode helpers
package mips_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  // Non-memory codes are always "aligned" so they never raise an error.
  function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] lsb);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return !lsb[0];
      MEM_LW, MEM_SW:          return lsb == 2'b00;
      default:                 return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the addressed byte/halfword of a load word
module load_align
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {24'h0, byte_sel};
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: req/ack data-bus loads/stores with stall and timeout
module mem_stage
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_wdata_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic [31:0] mem_wdata_o,
  output logic [4:0]  mem_waddr_o,
  output logic        mem_we_o,
  output logic        mem_stall_o,
  output logic        mem_align_err_o,
  output logic        mem_bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i
);

  mem_state_e  state;
  logic [7:0]  cnt;
  logic [31:0] addr_r, wdata_r, load_r;
  logic [3:0]  be_r, op_r;
  logic [1:0]  off_r;
  logic        we_r, tout_r;

  logic        is_mem, aligned, start, busy, timeout;
  logic [3:0]  be_n;
  logic [31:0] sdata_n, fmt;

  assign is_mem  = is_load(mem_op_i) || is_store(mem_op_i);
  assign aligned = is_aligned(mem_op_i, mem_addr_i[1:0]);
  assign start   = (state == MS_IDLE) && is_mem && aligned;
  assign busy    = (state == MS_BUSY);
  // An ack on the final wait cycle completes the transfer instead of timing out.
  assign timeout = busy && !dbus_ack_i && (cnt == 8'(MAX_WAIT - 1));

  always_comb begin
    be_n    = 4'b0000;
    sdata_n = 32'h0;
    case (mem_op_i)
      MEM_SB: begin
        be_n    = 4'b0001 << mem_addr_i[1:0];
        sdata_n = {4{mem_sdata_i[7:0]}};
      end
      MEM_SH: begin
        be_n    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        sdata_n = {2{mem_sdata_i[15:0]}};
      end
      MEM_SW: begin
        be_n    = 4'b1111;
        sdata_n = mem_sdata_i;
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .op     (op_r),
    .offset (off_r),
    .rdata  (dbus_rdata_i),
    .result (fmt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= MS_IDLE;
      cnt     <= 8'd0;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
      load_r  <= 32'h0;
      be_r    <= 4'b0000;
      op_r    <= 4'd0;
      off_r   <= 2'b00;
      we_r    <= 1'b0;
      tout_r  <= 1'b0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (start) begin
            addr_r  <= {mem_addr_i[31:2], 2'b00};
            wdata_r <= sdata_n;
            be_r    <= be_n;
            we_r    <= is_store(mem_op_i);
            op_r    <= mem_op_i;
            off_r   <= mem_addr_i[1:0];
            cnt     <= 8'd0;
            tout_r  <= 1'b0;
            state   <= MS_BUSY;
          end
        end
        MS_BUSY: begin
          cnt <= cnt + 8'd1;
          if (dbus_ack_i) begin
            if (is_load(op_r)) load_r <= fmt;
            state <= MS_DONE;
          end else if (timeout) begin
            tout_r <= 1'b1;
            state  <= MS_DONE;
          end
        end
        MS_DONE: begin
          cnt   <= 8'd0;
          state <= MS_IDLE;
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

  assign dbus_req_o    = busy;
  assign dbus_we_o     = busy && we_r;
  assign dbus_addr_o   = addr_r;
  assign dbus_be_o     = be_r;
  assign dbus_wdata_o  = wdata_r;
  assign mem_bus_err_o = timeout;

  // While stalled, MEM/WB is fed a bubble (we = 0).
  always_comb begin
    mem_wdata_o     = mem_wdata_i;
    mem_waddr_o     = mem_waddr_i;
    mem_we_o        = mem_we_i;
    mem_stall_o     = 1'b0;
    mem_align_err_o = 1'b0;
    if (!rst) begin
      mem_wdata_o = 32'h0;
      mem_waddr_o = 5'd0;
      mem_we_o    = 1'b0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (is_mem) begin
            mem_we_o = 1'b0;
            if (aligned) mem_stall_o = 1'b1;
            else         mem_align_err_o = 1'b1;
          end
        end
        MS_BUSY: begin
          mem_stall_o = 1'b1;
          mem_we_o    = 1'b0;
        end
        MS_DONE: begin
          if (is_load(op_r)) mem_wdata_o = load_r;
          mem_we_o = mem_we_i && !tout_r;
        end
        default: ;
      endcase
    end
  end

endmodule
